// File: rtl/tile_dispatch_pkg.sv
// Shared types for the tile job dispatcher: job word types, dispatcher
// states and the replay section sequence.
package tile_dispatch_pkg;

  // Type field position in the default 32-bit job word (29-bit payload).
  localparam int TYPE_W   = 3;
  localparam int TYPE_LSB = 29;
  localparam int TYPE_MSB = TYPE_LSB + TYPE_W - 1;

  typedef enum logic [2:0] {
    TYPE_ADDR   = 3'd0,
    TYPE_NLIMBS = 3'd1,
    TYPE_REAL   = 3'd2,
    TYPE_IMAG   = 3'd3,
    TYPE_ITER   = 3'd4,
    TYPE_SHIFT  = 3'd5,
    TYPE_RSVD6  = 3'd6,
    TYPE_RSVD7  = 3'd7
  } word_type_t;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    WAIT    = 2'd1,
    REPLAY  = 2'd2
  } disp_state_t;

  // Replay emits the job in this fixed order, whatever order it arrived in.
  typedef enum logic [2:0] {
    SEC_ADDR   = 3'd0,
    SEC_NLIMBS = 3'd1,
    SEC_REAL   = 3'd2,
    SEC_IMAG   = 3'd3,
    SEC_ITER   = 3'd4,
    SEC_SHIFT  = 3'd5
  } section_t;

  function automatic logic is_reserved(word_type_t t);
    return (t == TYPE_RSVD6) || (t == TYPE_RSVD7);
  endfunction

endpackage

// File: rtl/tile_job_dispatcher_rr_arbiter.sv
// Round-robin pick of one requester, searching upward from last+1 and
// wrapping. With a single requester this reduces to req[0].
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [W-1:0] grant,
  output logic         grant_valid
);

  // Lowest requester above last wins; otherwise lowest at or below last.
  // The second loop runs after the first so the upper side overrides.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    for (int j = N - 1; j >= 0; j--) begin
      if (req[j] && (j <= int'(last))) begin
        grant       = W'(j);
        grant_valid = 1'b1;
      end
    end
    for (int j = N - 1; j >= 0; j--) begin
      if (req[j] && (j > int'(last))) begin
        grant       = W'(j);
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tile_job_dispatcher.sv
// Tile job dispatcher: buffers one typed job, picks an idle solver
// round-robin and replays the job over the shared job bus.
// Optional DISPATCH_ERROR_CHECK_EN adds a sticky err output and discards
// malformed jobs instead of dispatching them.
module tile_job_dispatcher
  import tile_dispatch_pkg::*;
#(
  parameter int NUM_SOLVERS  = 4,
  parameter int MAX_LIMBS    = 8,
  parameter int PAYLOAD_BITS = 29,
  parameter int COUNT_BITS   = 16,
  localparam int TW = (NUM_SOLVERS > 1) ? $clog2(NUM_SOLVERS) : 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic [PAYLOAD_BITS+2:0]   in_data,
  input  logic                      in_end_of_stream,
  output logic                      in_ready,
  input  logic [NUM_SOLVERS-1:0]    solver_idle,
  output logic                      job_valid,
  output logic [TW-1:0]             job_target,
  output logic [2:0]                job_type,
  output logic [PAYLOAD_BITS-1:0]   job_data,
  output logic                      job_end,
  input  logic                      job_ready,
  output logic [COUNT_BITS-1:0]     dispatch_count
`ifdef DISPATCH_ERROR_CHECK_EN
  ,
  output logic                      err
`endif
);

  localparam int CW = $clog2(MAX_LIMBS + 1);
  localparam int IW = (MAX_LIMBS > 1) ? $clog2(MAX_LIMBS) : 1;

  disp_state_t state, state_n;
  section_t    sec;
  logic [CW-1:0] real_cnt, imag_cnt, rep_idx;
  logic [PAYLOAD_BITS-1:0] addr_q, nl_q, iter_q, shift_q;
  logic [PAYLOAD_BITS-1:0] real_buf [MAX_LIMBS];
  logic [PAYLOAD_BITS-1:0] imag_buf [MAX_LIMBS];
  logic [TW-1:0] last_target, grant;
  logic          grant_valid;
  logic          xfer, eos, job_done, job_drop;
  word_type_t    in_type;
  logic [PAYLOAD_BITS-1:0] in_pay;

  assign in_type   = word_type_t'(in_data[PAYLOAD_BITS +: TYPE_W]);
  assign in_pay    = in_data[PAYLOAD_BITS-1:0];
  assign in_ready  = (state == COLLECT);
  assign job_valid = (state == REPLAY);
  assign xfer      = in_valid && in_ready;
  assign eos       = xfer && in_end_of_stream;
  assign job_done  = (state == REPLAY) && job_ready && (sec == SEC_SHIFT);

  rr_arbiter #(.N(NUM_SOLVERS), .W(TW)) u_arb (
    .req         (solver_idle),
    .last        (last_target),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  // State register; reset lands in COLLECT from anywhere, including replay.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= COLLECT;
    else       state <= state_n;
  end

  // Next state and the replay word mux.
  always_comb begin
    state_n  = state;
    job_type = '0;
    job_data = '0;
    job_end  = 1'b0;
    case (state)
      COLLECT: if (eos) state_n = job_drop ? COLLECT : WAIT;
      WAIT:    if (grant_valid) state_n = REPLAY;
      REPLAY: begin
        case (sec)
          SEC_ADDR:   begin job_type = TYPE_ADDR;   job_data = addr_q; end
          SEC_NLIMBS: begin job_type = TYPE_NLIMBS; job_data = nl_q;   end
          SEC_REAL:   begin job_type = TYPE_REAL;   job_data = real_buf[rep_idx[IW-1:0]]; end
          SEC_IMAG:   begin job_type = TYPE_IMAG;   job_data = imag_buf[rep_idx[IW-1:0]]; end
          SEC_ITER:   begin job_type = TYPE_ITER;   job_data = iter_q; end
          default:    begin job_type = TYPE_SHIFT;  job_data = shift_q; job_end = 1'b1; end
        endcase
        if (job_done) state_n = COLLECT;
      end
      default: state_n = COLLECT;
    endcase
  end

  // Job storage; contents are don't-care after reset, so no reset here.
  // Scalars are last-wins, limbs beyond MAX_LIMBS and reserved words drop.
  always_ff @(posedge clock) begin
    if (xfer) begin
      case (in_type)
        TYPE_ADDR:   addr_q  <= in_pay;
        TYPE_NLIMBS: nl_q    <= in_pay;
        TYPE_REAL:   if (real_cnt != CW'(MAX_LIMBS)) real_buf[real_cnt[IW-1:0]] <= in_pay;
        TYPE_IMAG:   if (imag_cnt != CW'(MAX_LIMBS)) imag_buf[imag_cnt[IW-1:0]] <= in_pay;
        TYPE_ITER:   iter_q  <= in_pay;
        TYPE_SHIFT:  shift_q <= in_pay;
        default: ;
      endcase
    end
  end

  // Limb counters, target latch, replay sequencer and dispatch bookkeeping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      real_cnt       <= '0;
      imag_cnt       <= '0;
      sec            <= SEC_ADDR;
      rep_idx        <= '0;
      job_target     <= '0;
      last_target    <= TW'(NUM_SOLVERS - 1);
      dispatch_count <= '0;
    end else begin
      if (job_done || job_drop) begin
        real_cnt <= '0;
        imag_cnt <= '0;
      end else if (xfer && in_type == TYPE_REAL && real_cnt != CW'(MAX_LIMBS)) begin
        real_cnt <= real_cnt + CW'(1);
      end else if (xfer && in_type == TYPE_IMAG && imag_cnt != CW'(MAX_LIMBS)) begin
        imag_cnt <= imag_cnt + CW'(1);
      end

      if (state == WAIT && grant_valid) begin
        job_target <= grant;
        sec        <= SEC_ADDR;
        rep_idx    <= '0;
      end else if (state == REPLAY && job_ready) begin
        case (sec)
          SEC_ADDR:   sec <= SEC_NLIMBS;
          SEC_NLIMBS: sec <= (real_cnt != '0) ? SEC_REAL :
                             (imag_cnt != '0) ? SEC_IMAG : SEC_ITER;
          SEC_REAL: begin
            if (rep_idx + CW'(1) == real_cnt) begin
              rep_idx <= '0;
              sec     <= (imag_cnt != '0) ? SEC_IMAG : SEC_ITER;
            end else rep_idx <= rep_idx + CW'(1);
          end
          SEC_IMAG: begin
            if (rep_idx + CW'(1) == imag_cnt) begin
              rep_idx <= '0;
              sec     <= SEC_ITER;
            end else rep_idx <= rep_idx + CW'(1);
          end
          SEC_ITER:   sec <= SEC_SHIFT;
          default: begin
            dispatch_count <= dispatch_count + COUNT_BITS'(1);
            last_target    <= job_target;
          end
        endcase
      end
    end
  end

`ifdef DISPATCH_ERROR_CHECK_EN
  logic have_addr, have_nl, have_iter, have_shift, bad_q;
  logic word_bad, cnt_mismatch, missing;
  logic [CW-1:0] real_cnt_n, imag_cnt_n;
  logic [PAYLOAD_BITS-1:0] nl_n;

  // The end word is judged together with everything collected before it.
  always_comb begin
    word_bad   = xfer && (is_reserved(in_type) ||
                 (in_type == TYPE_REAL && real_cnt == CW'(MAX_LIMBS)) ||
                 (in_type == TYPE_IMAG && imag_cnt == CW'(MAX_LIMBS)));
    real_cnt_n = real_cnt + CW'(in_type == TYPE_REAL && real_cnt != CW'(MAX_LIMBS));
    imag_cnt_n = imag_cnt + CW'(in_type == TYPE_IMAG && imag_cnt != CW'(MAX_LIMBS));
    nl_n       = (in_type == TYPE_NLIMBS) ? in_pay : nl_q;
    cnt_mismatch = (PAYLOAD_BITS'(real_cnt_n) != nl_n) ||
                   (PAYLOAD_BITS'(imag_cnt_n) != nl_n);
    missing    = !(have_addr  || in_type == TYPE_ADDR)   ||
                 !(have_nl    || in_type == TYPE_NLIMBS) ||
                 !(have_iter  || in_type == TYPE_ITER)   ||
                 !(have_shift || in_type == TYPE_SHIFT);
    job_drop   = eos && (bad_q || word_bad || cnt_mismatch || missing);
  end

  // Per-job presence/bad flags cleared at end of stream; err is sticky.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      have_addr <= 1'b0; have_nl <= 1'b0; have_iter <= 1'b0; have_shift <= 1'b0;
      bad_q     <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= err | word_bad | job_drop;
      if (eos) begin
        have_addr <= 1'b0; have_nl <= 1'b0; have_iter <= 1'b0; have_shift <= 1'b0;
        bad_q     <= 1'b0;
      end else if (xfer) begin
        bad_q <= bad_q | word_bad;
        if (in_type == TYPE_ADDR)   have_addr  <= 1'b1;
        if (in_type == TYPE_NLIMBS) have_nl    <= 1'b1;
        if (in_type == TYPE_ITER)   have_iter  <= 1'b1;
        if (in_type == TYPE_SHIFT)  have_shift <= 1'b1;
      end
    end
  end
`else
  assign job_drop = 1'b0;
`endif

endmodule

// File: tb/tb_tile_job_dispatcher.sv
// Randomized self-checking bench for tile_job_dispatcher with a queue-based
// reference model of job assembly, replay order and round-robin choice.
module tb_tile_job_dispatcher;

  localparam int NS = 4;
  localparam int ML = 8;
  localparam int PB = 29;
  localparam int CB = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic [PB+2:0] in_data = '0;
  logic in_end_of_stream = 1'b0;
  logic in_ready;
  logic [NS-1:0] solver_idle = '1;
  logic job_valid;
  logic [1:0] job_target;
  logic [2:0] job_type;
  logic [PB-1:0] job_data;
  logic job_end;
  logic job_ready = 1'b1;
  logic [CB-1:0] dispatch_count;
`ifdef DISPATCH_ERROR_CHECK_EN
  logic err;
`endif

  always #5 clock = ~clock;

  tile_job_dispatcher #(.NUM_SOLVERS(NS), .MAX_LIMBS(ML), .PAYLOAD_BITS(PB), .COUNT_BITS(CB)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_end_of_stream(in_end_of_stream), .in_ready(in_ready), .solver_idle(solver_idle),
    .job_valid(job_valid), .job_target(job_target), .job_type(job_type), .job_data(job_data),
    .job_end(job_end), .job_ready(job_ready), .dispatch_count(dispatch_count)
`ifdef DISPATCH_ERROR_CHECK_EN
    , .err(err)
`endif
  );

  typedef struct packed { logic [2:0] t; logic [PB-1:0] p; } word_s;

  word_s job_q[$];
  word_s exp_q[$];
  word_s got_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int model_last = NS - 1;
  int model_count = 0;
  int got_target, first_cyc, stab_bad, end_bad;
  bit timed_out;

  // Reference: what the solver must see for the job in job_q.
  function automatic void build_expected();
    logic [PB-1:0] a, nl, it, sh;
    word_s re[$];
    word_s im[$];
    a = '0; nl = '0; it = '0; sh = '0;
    foreach (job_q[i]) begin
      case (job_q[i].t)
        3'd0: a  = job_q[i].p;
        3'd1: nl = job_q[i].p;
        3'd2: if (re.size() < ML) re.push_back(job_q[i]);
        3'd3: if (im.size() < ML) im.push_back(job_q[i]);
        3'd4: it = job_q[i].p;
        3'd5: sh = job_q[i].p;
        default: ;
      endcase
    end
    exp_q.delete();
    exp_q.push_back({3'd0, a});
    exp_q.push_back({3'd1, nl});
    foreach (re[i]) exp_q.push_back(re[i]);
    foreach (im[i]) exp_q.push_back(im[i]);
    exp_q.push_back({3'd4, it});
    exp_q.push_back({3'd5, sh});
  endfunction

  // Reference round-robin: first idle solver after the previous target.
  function automatic int model_pick(logic [NS-1:0] idle);
    for (int k = 1; k <= NS; k++) begin
      int c = (model_last + k) % NS;
      if (idle[c]) return c;
    end
    return -1;
  endfunction

  function automatic bit words_match();
    if (got_q.size() != exp_q.size()) return 1'b0;
    foreach (exp_q[i]) if (got_q[i] !== exp_q[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Random job: scalars, interleaved limbs, optional last-wins repeat, shift last.
  task automatic gen_job(input int nr, input int ni, input int nl, input bit rep);
    int ri = 0, ii = 0;
    job_q.delete();
    job_q.push_back({3'd0, PB'($urandom)});
    job_q.push_back({3'd1, PB'(nl)});
    while (ri < nr || ii < ni) begin
      if (ri < nr && (ii >= ni || $urandom_range(0, 1) == 0)) begin
        job_q.push_back({3'd2, PB'($urandom)}); ri++;
      end else begin
        job_q.push_back({3'd3, PB'($urandom)}); ii++;
      end
    end
    job_q.push_back({3'd4, PB'($urandom)});
    if (rep) job_q.push_back({3'd0, PB'($urandom)});
    job_q.push_back({3'd5, PB'($urandom)});
  endtask

  task automatic send_job(input int gap_at, input int gap_len);
    foreach (job_q[i]) begin
      int n = 0;
      if (i == gap_at) repeat (gap_len) begin @(negedge clock); in_valid = 1'b0; end
      @(negedge clock);
      in_valid = 1'b1;
      in_data = {job_q[i].t, job_q[i].p};
      in_end_of_stream = (i == job_q.size() - 1);
      while (!in_ready && n < 50) begin @(negedge clock); n++; end
      if (n >= 50) begin
        n_checks++; n_errors++;
        $display("FAIL send_timeout word %0d: in_ready stayed 0, required 1", i);
      end
    end
    @(negedge clock);
    in_valid = 1'b0;
    in_end_of_stream = 1'b0;
  endtask

  // Bus monitor: collects one replayed job. mode 0 ready=1, 1 random, 2 toggle.
  task automatic recv_job(input int mode, input int bound);
    word_s held;
    bit held_v = 0, fin = 0;
    int cyc = 0;
    got_q.delete();
    first_cyc = -1; stab_bad = 0; end_bad = 0; got_target = -1;
    while (!fin && cyc < bound) begin
      @(negedge clock);
      cyc++;
      job_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : ~job_ready;
      if (job_valid) begin
        if (first_cyc < 0) begin first_cyc = cyc; got_target = int'(job_target); end
        if (int'(job_target) != got_target) stab_bad++;
        if (held_v && {job_type, job_data} !== held) stab_bad++;
        if (job_ready) begin
          got_q.push_back({job_type, job_data});
          if (job_end !== (got_q.size() == exp_q.size())) end_bad++;
          if (job_end) fin = 1;
          held_v = 0;
        end else begin
          held = {job_type, job_data};
          held_v = 1;
        end
      end
    end
    job_ready = 1'b1;
    timed_out = !fin;
    @(negedge clock);
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if ({in_ready, job_valid, job_end, job_type, job_data, job_target, dispatch_count} !== {1'b1, 2'b0, 3'b0, PB'(0), 2'b0, CB'(0)}) begin
      n_errors++;
      $display("FAIL reset_outputs ready=%b valid=%b end=%b type=%0d data=%0h tgt=%0d cnt=%0d", in_ready, job_valid, job_end, job_type, job_data, job_target, dispatch_count);
    end
`ifdef DISPATCH_ERROR_CHECK_EN
    n_checks++;
    if (err !== 1'b0) begin n_errors++; $display("FAIL reset_err got=%b exp=0", err); end
`endif
    @(negedge clock); reset = 1'b0;
    @(negedge clock);
    n_checks++;
    if (in_ready !== 1'b1) begin n_errors++; $display("FAIL post_reset_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_basic();
    int exp_t;
    job_q = '{'{3'd0, PB'(0)}, '{3'd1, PB'(2)}, '{3'd2, PB'(5)}, '{3'd2, PB'(6)},
              '{3'd3, PB'(7)}, '{3'd3, PB'(8)}, '{3'd4, PB'(10)}, '{3'd5, PB'(4)}};
    build_expected();
    solver_idle = '1;
    send_job(-1, 0);
    n_checks++;
    if (in_ready !== 1'b0) begin n_errors++; $display("FAIL basic_wait_ready got=%b exp=0", in_ready); end
    recv_job(0, 100);
    exp_t = model_pick(solver_idle); model_last = exp_t; model_count++;
    n_checks++;
    if (timed_out || !words_match() || end_bad != 0) begin
      n_errors++; $display("FAIL basic_words got %0d words exp %0d end_bad=%0d", got_q.size(), exp_q.size(), end_bad);
    end
    n_checks++;
    if (first_cyc != 1) begin n_errors++; $display("FAIL basic_latency got=%0d exp=1", first_cyc); end
    n_checks++;
    if (got_target != exp_t) begin n_errors++; $display("FAIL basic_target got=%0d exp=%0d", got_target, exp_t); end
    n_checks++;
    if (dispatch_count !== CB'(model_count)) begin n_errors++; $display("FAIL basic_count got=%0d exp=%0d", dispatch_count, model_count); end
  endtask

  task automatic test_round_robin();
    for (int j = 0; j < 4; j++) begin
      int exp_t;
      solver_idle = (j == 3) ? 4'b0001 : 4'b1111;
      gen_job(2, 2, 2, 0);
      build_expected();
      send_job(-1, 0);
      recv_job(0, 100);
      exp_t = model_pick(solver_idle); model_last = exp_t; model_count++;
      n_checks++;
      if (timed_out || !words_match() || got_target != exp_t) begin
        n_errors++; $display("FAIL rr_job%0d target got=%0d exp=%0d words %0d/%0d", j, got_target, exp_t, got_q.size(), exp_q.size());
      end
    end
    n_checks++;
    if (dispatch_count !== CB'(model_count)) begin n_errors++; $display("FAIL rr_count got=%0d exp=%0d", dispatch_count, model_count); end
  endtask

  task automatic test_stall_backpressure();
    int bad = 0, exp_t;
    solver_idle = '0;
    gen_job(3, 1, 3, 0);
    build_expected();
    send_job(-1, 0);
    repeat (5) begin
      @(negedge clock);
      if (in_ready !== 1'b0 || job_valid !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_errors++; $display("FAIL stall_hold %0d cycles with ready/valid set, exp 0", bad); end
    solver_idle = 4'b1000;
    recv_job(2, 100);
    exp_t = model_pick(solver_idle); model_last = exp_t; model_count++;
    n_checks++;
    if (got_target != exp_t) begin n_errors++; $display("FAIL stall_target got=%0d exp=%0d", got_target, exp_t); end
    n_checks++;
    if (timed_out || !words_match() || stab_bad != 0 || end_bad != 0) begin
      n_errors++; $display("FAIL stall_words got %0d exp %0d unstable=%0d end_bad=%0d", got_q.size(), exp_q.size(), stab_bad, end_bad);
    end
  endtask

  task automatic test_input_gaps();
    int exp_t;
    solver_idle = '1;
    job_q = '{'{3'd0, PB'(0)}, '{3'd1, PB'(2)}, '{3'd2, PB'(5)}, '{3'd2, PB'(6)},
              '{3'd3, PB'(7)}, '{3'd3, PB'(8)}, '{3'd4, PB'(10)}, '{3'd5, PB'(4)}};
    build_expected();
    send_job(5, 3);
    recv_job(0, 100);
    exp_t = model_pick(solver_idle); model_last = exp_t; model_count++;
    n_checks++;
    if (timed_out || !words_match() || got_target != exp_t) begin
      n_errors++; $display("FAIL gap_words got %0d exp %0d tgt=%0d exp=%0d", got_q.size(), exp_q.size(), got_target, exp_t);
    end
  endtask

  task automatic test_random();
    for (int j = 0; j < 20; j++) begin
      int nr, ni, exp_t;
      nr = $urandom_range(0, ML);
`ifdef DISPATCH_ERROR_CHECK_EN
      ni = nr;
`else
      ni = $urandom_range(0, ML);
`endif
      solver_idle = NS'($urandom_range(1, 15));
      gen_job(nr, ni, nr, 1'($urandom_range(0, 1)));
      build_expected();
      send_job($urandom_range(1, 4), $urandom_range(0, 3));
      recv_job(1, 300);
      exp_t = model_pick(solver_idle); model_last = exp_t; model_count++;
      n_checks++;
      if (timed_out || !words_match() || stab_bad != 0 || end_bad != 0) begin
        n_errors++; $display("FAIL rand%0d_words got %0d exp %0d unstable=%0d end_bad=%0d", j, got_q.size(), exp_q.size(), stab_bad, end_bad);
      end
      n_checks++;
      if (got_target != exp_t || dispatch_count !== CB'(model_count)) begin
        n_errors++; $display("FAIL rand%0d_target tgt=%0d exp=%0d cnt=%0d exp=%0d", j, got_target, exp_t, dispatch_count, model_count);
      end
    end
  endtask

`ifndef DISPATCH_ERROR_CHECK_EN
  // Overflowing limbs and reserved words are dropped; num_limbs replays as sent.
  task automatic test_overflow_reserved();
    int exp_t;
    gen_job(ML + 2, 0, 3, 0);
    job_q.insert(2, '{3'd6, PB'(123)});
    job_q.insert(4, '{3'd7, PB'(456)});
    build_expected();
    solver_idle = '1;
    send_job(-1, 0);
    recv_job(0, 100);
    exp_t = model_pick(solver_idle); model_last = exp_t; model_count++;
    n_checks++;
    if (timed_out || !words_match() || got_target != exp_t) begin
      n_errors++; $display("FAIL overflow_words got %0d exp %0d tgt=%0d exp=%0d", got_q.size(), exp_q.size(), got_target, exp_t);
    end
  endtask
`else
  task automatic test_error_discard();
    int bad = 0, exp_t;
    solver_idle = '1;
    gen_job(3, 2, 2, 0);
    send_job(-1, 0);
    n_checks++;
    if (err !== 1'b1 || in_ready !== 1'b1) begin n_errors++; $display("FAIL err_set err=%b ready=%b exp 1/1", err, in_ready); end
    repeat (4) begin @(negedge clock); if (job_valid !== 1'b0) bad++; end
    n_checks++;
    if (bad != 0 || dispatch_count !== CB'(model_count)) begin
      n_errors++; $display("FAIL err_discard valid_cycles=%0d cnt=%0d exp=%0d", bad, dispatch_count, model_count);
    end
    gen_job(2, 2, 2, 0);
    build_expected();
    send_job(-1, 0);
    recv_job(0, 100);
    exp_t = model_pick(solver_idle); model_last = exp_t; model_count++;
    n_checks++;
    if (timed_out || !words_match() || got_target != exp_t || dispatch_count !== CB'(model_count) || err !== 1'b1) begin
      n_errors++; $display("FAIL err_next_job words %0d/%0d tgt=%0d exp=%0d cnt=%0d err=%b", got_q.size(), exp_q.size(), got_target, exp_t, dispatch_count, err);
    end
  endtask
`endif

  task automatic test_reset_mid_replay();
    int cnt = 0, cyc = 0, exp_t;
    solver_idle = '1;
    gen_job(2, 2, 2, 0);
    build_expected();
    send_job(-1, 0);
    while (cnt < 3 && cyc < 50) begin
      @(negedge clock); cyc++;
      job_ready = 1'b1;
      if (job_valid) cnt++;
    end
    @(negedge clock);
    n_checks++;
    if (job_valid !== 1'b1) begin n_errors++; $display("FAIL mid_replay_active got=%b exp=1", job_valid); end
    reset = 1'b1;
    #1;
    n_checks++;
    if (job_valid !== 1'b0 || dispatch_count !== CB'(0)) begin
      n_errors++; $display("FAIL async_reset valid=%b cnt=%0d exp 0/0", job_valid, dispatch_count);
    end
    @(negedge clock); reset = 1'b0;
    model_last = NS - 1; model_count = 0;
    @(negedge clock);
    n_checks++;
    if (in_ready !== 1'b1 || job_valid !== 1'b0) begin n_errors++; $display("FAIL reset_release ready=%b valid=%b exp 1/0", in_ready, job_valid); end
    send_job(-1, 0);
    recv_job(0, 100);
    exp_t = model_pick(solver_idle); model_last = exp_t; model_count++;
    n_checks++;
    if (timed_out || !words_match() || got_target != exp_t || dispatch_count !== CB'(model_count)) begin
      n_errors++; $display("FAIL after_reset_job tgt=%0d exp=%0d cnt=%0d exp=%0d", got_target, exp_t, dispatch_count, model_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_stall_backpressure();
    test_input_gaps();
    test_random();
`ifndef DISPATCH_ERROR_CHECK_EN
    test_overflow_reserved();
`else
    test_error_discard();
`endif
    test_reset_mid_replay();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
